// File: rtl/dmem_access_unit_pkg.sv
// rtl/dmem_access_unit_pkg.sv - shared funct3 constants and load/store FSM state type
package riscv_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            ok = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                 (funct3 == LBU) || (funct3 == LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// rtl/dmem_access_unit_if.sv - execute, data-memory and writeback signals of the load/store unit
interface dmem_access_unit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [31:0] wb_data;
    logic [2:0]  wb_size;
    logic [4:0]  wb_rd;
    logic        access_fault;

    // slave: the load/store unit's own view
    modport slave (
        input  ex_valid, ex_we, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_data, wb_size, wb_rd, access_fault
    );

    modport master (
        output ex_valid, ex_we, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_data, wb_size, wb_rd, access_fault
    );
endinterface

// File: rtl/dmem_access_unit_lane_align.sv
// rtl/dmem_access_unit_lane_align.sv - byte-lane enables, store replication, load shift and fault decode
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        fault_o
);

    logic misalign;

    always_comb begin
        be_o     = 4'b1111;
        wdata_o  = wdata_i;
        misalign = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o     = 4'b0011 << addr_lo_i;
                wdata_o  = {2{wdata_i[15:0]}};
                misalign = addr_lo_i[0];
            end
            default: begin
                misalign = (addr_lo_i != 2'b00);
            end
        endcase
        fault_o = misalign || !funct3_legal(we_i, funct3_i);
        rdata_o = rdata_i >> {addr_lo_i, 3'b000};
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - single-outstanding memory-stage load/store unit
module dmem_access_unit
    import riscv_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dmem_access_unit_if.slave bus
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_size_q, wb_size_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        fault_q, fault_d;

    logic        in_idle;
    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_fault;

    assign in_idle = (state_q == ST_IDLE);

    // One aligner: decodes the incoming op in IDLE, shifts the response with the latched offset later
    assign al_we     = in_idle ? bus.ex_we         : we_q;
    assign al_funct3 = in_idle ? bus.ex_funct3     : funct3_q;
    assign al_off    = in_idle ? bus.ex_addr[1:0]  : off_q;

    dmem_lane_align u_align (
        .we_i      (al_we),
        .funct3_i  (al_funct3),
        .addr_lo_i (al_off),
        .wdata_i   (bus.ex_wdata),
        .rdata_i   (bus.mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata),
        .fault_o   (al_fault)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_size_d   = wb_size_q;
        wb_rd_d     = wb_rd_q;
        fault_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ex_valid) begin
                    if (al_fault) begin
                        fault_d = 1'b1;
                    end else begin
                        funct3_d    = bus.ex_funct3;
                        we_d        = bus.ex_we;
                        off_d       = bus.ex_addr[1:0];
                        rd_d        = bus.ex_rd;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.ex_we;
                        mem_addr_d  = {bus.ex_addr[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = we_q ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = al_rdata;
                    wb_size_d  = funct3_q;
                    wb_rd_d    = rd_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 32'd0;
            wb_size_q   <= 3'b000;
            wb_rd_q     <= 5'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_size_q   <= wb_size_d;
            wb_rd_q     <= wb_rd_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.ex_ready     = in_idle;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_size      = wb_size_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.access_fault = fault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - vector table, random ops against a reference model, and corner sequences
module tb_dmem_access_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    dmem_access_unit_if bus ();

    dmem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gdly;
        int          rdly;
        logic        flt;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: size in bytes, natural alignment, byte-lane arithmetic
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic flt, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] wb);
        int  nbytes;
        int  off;
        bit  legal;
        nbytes = 1 << f3[1:0];
        off    = int'(addr % 4);
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        flt = !legal || ((addr % nbytes) != 0);
        be  = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      wd = 32'(wdata[7:0]) * 32'h0101_0101;
        else if (nbytes == 2) wd = 32'(wdata[15:0]) * 32'h0001_0001;
        else                  wd = wdata;
        wb = rdata / (32'd1 << (8 * off));
    endfunction

    task automatic run_op(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input int gdly, input int rdly,
                          input logic efault, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] ewb);
        chk({nm, ".ready_idle"}, 32'(bus.ex_ready), 32'd1);
        bus.ex_valid  = 1'b1;
        bus.ex_we     = we;
        bus.ex_funct3 = f3;
        bus.ex_addr   = addr;
        bus.ex_wdata  = wdata;
        bus.ex_rd     = rd;
        @(negedge clk);
        bus.ex_valid  = 1'b0;
        bus.ex_addr   = $urandom;
        bus.ex_wdata  = $urandom;
        bus.ex_funct3 = 3'($urandom);
        bus.ex_rd     = 5'($urandom);
        if (efault) begin
            chk({nm, ".fault"}, 32'(bus.access_fault), 32'd1);
            chk({nm, ".fault_noreq"}, 32'(bus.mem_req), 32'd0);
            chk({nm, ".fault_ready"}, 32'(bus.ex_ready), 32'd1);
            @(negedge clk);
            chk({nm, ".fault_pulse"}, 32'(bus.access_fault), 32'd0);
            chk({nm, ".fault_noreq2"}, 32'(bus.mem_req), 32'd0);
            return;
        end
        chk({nm, ".nofault"}, 32'(bus.access_fault), 32'd0);
        for (int k = 0; k <= gdly; k++) begin
            chk({nm, ".req"}, 32'(bus.mem_req), 32'd1);
            chk({nm, ".addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
            chk({nm, ".be"}, 32'(bus.mem_be), 32'(ebe));
            chk({nm, ".we"}, 32'(bus.mem_we), 32'(we));
            if (we) chk({nm, ".wdata"}, bus.mem_wdata, ewd);
            chk({nm, ".ready_req"}, 32'(bus.ex_ready), 32'd0);
            bus.mem_gnt    = (k == gdly);
            bus.mem_rvalid = (k != gdly) ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        chk({nm, ".req_drop"}, 32'(bus.mem_req), 32'd0);
        if (we) begin
            chk({nm, ".ready_after_st"}, 32'(bus.ex_ready), 32'd1);
            chk({nm, ".no_wb_st"}, 32'(bus.wb_valid), 32'd0);
            return;
        end
        for (int k = 0; k < rdly; k++) begin
            chk({nm, ".wait_wb"}, 32'(bus.wb_valid), 32'd0);
            @(negedge clk);
        end
        chk({nm, ".ready_resp"}, 32'(bus.ex_ready), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        chk({nm, ".wb_valid"}, 32'(bus.wb_valid), 32'd1);
        chk({nm, ".wb_data"}, bus.wb_data, ewb);
        chk({nm, ".wb_size"}, 32'(bus.wb_size), 32'(f3));
        chk({nm, ".wb_rd"}, 32'(bus.wb_rd), 32'(rd));
        chk({nm, ".ready_wb"}, 32'(bus.ex_ready), 32'd1);
        @(negedge clk);
        chk({nm, ".wb_pulse"}, 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, ".req"}, 32'(bus.mem_req), 32'd0);
        chk({nm, ".we"}, 32'(bus.mem_we), 32'd0);
        chk({nm, ".addr"}, bus.mem_addr, 32'd0);
        chk({nm, ".be"}, 32'(bus.mem_be), 32'd0);
        chk({nm, ".wdata"}, bus.mem_wdata, 32'd0);
        chk({nm, ".wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({nm, ".wb_data"}, bus.wb_data, 32'd0);
        chk({nm, ".wb_size"}, 32'(bus.wb_size), 32'd0);
        chk({nm, ".wb_rd"}, 32'(bus.wb_rd), 32'd0);
        chk({nm, ".fault"}, 32'(bus.access_fault), 32'd0);
        chk({nm, ".ready"}, 32'(bus.ex_ready), 32'd1);
    endtask

    initial begin
        logic        r_we, r_flt;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wdata, r_rdata, r_wd, r_wb;
        logic [3:0]  r_be;

        vecs[0] = '{"lbu_1003", 1'b0, 3'b100, 32'h1003, 32'h0,        32'hAABBCCDD, 0, 0, 1'b0, 4'b1000, 32'h0,        32'h000000AA};
        vecs[1] = '{"sh_2002",  1'b1, 3'b001, 32'h2002, 32'h12345678, 32'h0,        3, 0, 1'b0, 4'b1100, 32'h56785678, 32'h0};
        vecs[2] = '{"lw_3001",  1'b0, 3'b010, 32'h3001, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[3] = '{"ld_f011",  1'b0, 3'b011, 32'h0040, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[4] = '{"st_f100",  1'b1, 3'b100, 32'h0040, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[5] = '{"lh_0010",  1'b0, 3'b001, 32'h0010, 32'h0,        32'h11223344, 0, 1, 1'b0, 4'b0011, 32'h0,        32'h11223344};
        vecs[6] = '{"lhu_0012", 1'b0, 3'b101, 32'h0012, 32'h0,        32'h11223344, 2, 2, 1'b0, 4'b1100, 32'h0,        32'h00001122};
        vecs[7] = '{"sw_0020",  1'b1, 3'b010, 32'h0020, 32'hCAFEBABE, 32'h0,        1, 0, 1'b0, 4'b1111, 32'hCAFEBABE, 32'h0};
        vecs[8] = '{"lh_0011",  1'b0, 3'b001, 32'h0011, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[9] = '{"sw_0022",  1'b1, 3'b010, 32'h0022, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};

        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_we = 1'b0; bus.ex_funct3 = 3'b000;
        bus.ex_addr = 32'd0; bus.ex_wdata = 32'd0; bus.ex_rd = 5'd0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].nm, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 5'(i + 1),
                   vecs[i].rdata, vecs[i].gdly, vecs[i].rdly, vecs[i].flt, vecs[i].be,
                   vecs[i].wd, vecs[i].wb);
        end

        // Back-to-back: LW then SB held on ex_valid, accepted as the load result appears
        bus.ex_valid = 1'b1; bus.ex_we = 1'b0; bus.ex_funct3 = 3'b010;
        bus.ex_addr = 32'h0; bus.ex_rd = 5'd7;
        @(negedge clk);
        chk("b2b.lw_req", 32'(bus.mem_req), 32'd1);
        bus.ex_we = 1'b1; bus.ex_funct3 = 3'b000; bus.ex_addr = 32'h5; bus.ex_wdata = 32'h000000EE;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("b2b.resp_ready", 32'(bus.ex_ready), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h01020304;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("b2b.wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("b2b.wb_data", bus.wb_data, 32'h01020304);
        chk("b2b.ready_at_wb", 32'(bus.ex_ready), 32'd1);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("b2b.sb_req", 32'(bus.mem_req), 32'd1);
        chk("b2b.sb_addr", bus.mem_addr, 32'h4);
        chk("b2b.sb_be", 32'(bus.mem_be), 32'b0010);
        chk("b2b.sb_wdata", bus.mem_wdata, 32'hEEEEEEEE);
        chk("b2b.sb_we", 32'(bus.mem_we), 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("b2b.sb_done", 32'(bus.ex_ready), 32'd1);

        // Reset while waiting for the response; the late rvalid must be dropped
        bus.ex_valid = 1'b1; bus.ex_we = 1'b0; bus.ex_funct3 = 3'b010;
        bus.ex_addr = 32'h8; bus.ex_rd = 5'd9;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("rst_resp.in_resp", 32'(bus.ex_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        chk_zero_outputs("rst_resp.after_rst");
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk_zero_outputs("rst_resp.late_rvalid");
        run_op("post_rst_sw", 1'b1, 3'b010, 32'h100, 32'h89ABCDEF, 5'd3, 32'h0, 0, 0,
               1'b0, 4'b1111, 32'h89ABCDEF, 32'h0);

        for (int n = 0; n < 60; n++) begin
            r_we    = 1'($urandom);
            r_f3    = 3'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            model(r_we, r_f3, r_addr, r_wdata, r_rdata, r_flt, r_be, r_wd, r_wb);
            run_op($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wdata, 5'($urandom), r_rdata,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   r_flt, r_be, r_wd, r_wb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
